cpu_boot_seq: RTL and testbench
===============================

# cpu_boot_seq

Boot/run sequencer for the embedded 16-bit stack CPU. Accepts a code image from the host as a stream of 16-bit words, buffers them in a small FIFO, then drives the CPU's two-bit reset vector through LOAD and RUN phases. During LOAD it presents exactly one word per clock on the CPU's parallel load bus. It also generates the one-cycle `boot_done` that zeroes the CPU program counter, and it supports host halt/restart.

## Interface
- `CODE_WORDS`, 1024: number of 16-bit words loaded, written to CPU code addresses 0..CODE_WORDS-1.
- `FIFO_DEPTH`, 16: input buffer depth in words; power of two, ≥ 4.
- `PRIME`, 16: words buffered before LOAD may begin; 1 ≤ PRIME ≤ FIFO_DEPTH.

- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle pulse that begins a load; honoured in IDLE only.
- `halt`  in  1: one-cycle pulse that returns to IDLE from any state.
- `in_data`  in  16: host code word.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: word accepted on `in_valid && in_ready`.
- `cpu_rst`  out  2: CPU reset vector; bit index 1 = LOAD, bit index 2 = RUN (`[2:1]`).
- `par`  out  16: load word to the CPU.
- `boot_done`  out  1: one-cycle pulse that zeroes the CPU pc.
- `running`  out  1: state is RUN.
- `busy`  out  1: state is FILL, LOAD or BOOT.
- `err_underrun`  out  1: sticky; set on FIFO empty during LOAD, cleared by `start`.
- `words_loaded`  out  11: count of words presented during LOAD.

## Operation
- States: IDLE, FILL, LOAD, BOOT, RUN.
- **IDLE**
  - `cpu_rst`=2'b00; `in_ready`=0.
  - On `start`: clear FIFO, `words_loaded`, accept counter and `err_underrun`; go to FILL.
- **FILL**
  - `cpu_rst`=2'b00.
  - `in_ready` = FIFO not full AND accepted < CODE_WORDS.
  - When FIFO count ≥ PRIME, or accepted == CODE_WORDS: go to LOAD.
- **LOAD**
  - `cpu_rst`=2'b01 (LOAD only).
  - Each cycle pop one word to the registered `par` and increment `words_loaded`.
  - Acceptance continues under the same `in_ready` rule; a push and a pop in the same cycle leave the count unchanged.
  - If the FIFO is empty at a pop cycle while `words_loaded` < CODE_WORDS: set `err_underrun`, go to IDLE. The CPU pc cannot stall, so the load is aborted.
  - After the pop of word CODE_WORDS-1: go to BOOT.
- **BOOT**, one cycle
  - `cpu_rst`=2'b10, `boot_done`=1.
  - Go to RUN.
- **RUN**
  - `cpu_rst`=2'b10, `boot_done`=0, `in_ready`=0.
  - Words offered now are not accepted.
- **halt**
  - In any non-IDLE state: next state IDLE, `cpu_rst`=2'b00 next cycle.
  - FIFO is flushed; `err_underrun` is unchanged.
  - `halt` wins over `start` and over every state transition in the same cycle.
- `start` outside IDLE is ignored.
- Counters are 11 bits. The accept counter saturates at CODE_WORDS; no wrap.

## Timing
- Reset values (`rst_n`=0): state IDLE, `cpu_rst`=00, `par`=16'h8000 (nop), `boot_done`=0, `in_ready`=0, `running`=0, `busy`=0, `err_underrun`=0, `words_loaded`=0, FIFO empty.
- Reset asserted mid-operation takes effect immediately (asynchronous).
- All outputs are registered except `in_ready`, which is combinational from state, FIFO count and accept counter.
- `start` at cycle t gives FILL at t+1 and `in_ready` able to go high at t+1.
- In the first LOAD cycle, `cpu_rst`=01 and `par`=word0 appear on the same edge, so word k is valid in LOAD cycle k and lands at CPU address k.
- `par` holds its last value outside LOAD.
- LOAD lasts exactly CODE_WORDS cycles; BOOT follows immediately; RUN begins the cycle after `boot_done`.
- Fastest load, with the host streaming one word per cycle and no stalls: PRIME cycles of FILL + CODE_WORDS + 1 cycles to RUN.

## Test plan
- **Nominal load.** CODE_WORDS=8, PRIME=4; host streams 0x1000..0x1007 with no gaps.
  - `par` sequence 0x1000..0x1007 on 8 consecutive cycles with `cpu_rst`=01.
  - Then one cycle of `cpu_rst`=10 with `boot_done`=1; then `running`=1.
  - `words_loaded`=8.
- **Underrun.** Host delivers 4 words, pauses 10 cycles.
  - Fifth LOAD cycle: `err_underrun`=1, state IDLE, `cpu_rst`=00.
  - Next `start` clears `err_underrun`.
- **Short image.** CODE_WORDS=3 < PRIME=4.
  - LOAD entered after 3 accepts; no 4th word is accepted (`in_ready`=0 after the 3rd).
- **Backpressure.** FIFO_DEPTH=4; host streams continuously.
  - `in_ready` drops while the FIFO is full in FILL.
  - No word is lost or duplicated; checked against a reference queue.
- **Halt in RUN and in LOAD.**
  - `cpu_rst`→00 one cycle after `halt`; FIFO empty.
  - `halt` and `start` in the same cycle → IDLE.
- **Async reset mid-LOAD.** Pulse `rst_n` low for less than one clock.
  - All outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/cpu_boot_seq_if.sv
// Host code stream plus the CPU-facing load bus of the boot sequencer.
// master = host/CPU side (drives the stream), slave = sequencer.
interface cpu_boot_seq_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [2:1]  cpu_rst;
  logic [15:0] par;
  logic        boot_done;

  modport master (output in_data, in_valid, input in_ready, cpu_rst, par, boot_done);
  modport slave  (input in_data, in_valid, output in_ready, cpu_rst, par, boot_done);
endinterface

// File: rtl/cpu_boot_seq.sv
// Boot/run sequencer: buffers the host code image in a small FIFO and streams it
// one word per clock onto the CPU load bus, then releases the CPU into RUN.
module cpu_boot_seq #(
  parameter int CODE_WORDS = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  cpu_boot_seq_if.slave bus,
  output logic          running,
  output logic          busy,
  output logic          err_underrun,
  output logic [10:0]   words_loaded
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [10:0]   CODE_N  = 11'(CODE_WORDS);
  localparam logic [CW-1:0] PRIME_N = CW'(PRIME);
  localparam logic [CW-1:0] DEPTH_N = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LOAD, S_BOOT, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, avail;
  logic [10:0]   acc_q, acc_d, wl_q, wl_d;
  logic [15:0]   par_q, par_d, head;
  logic [2:1]    cpu_rst_q, cpu_rst_d;
  logic          boot_q, boot_d, run_q, run_d, busy_q, busy_d, err_q, err_d;
  logic          in_ready, push, pop, flush;

  assign in_ready = ((state_q == S_FILL) || (state_q == S_LOAD)) &&
                    (cnt_q != DEPTH_N) && (acc_q < CODE_N);
  assign push     = in_ready && bus.in_valid;
  // A word arriving into an empty FIFO is forwarded straight to the pop.
  assign head     = (cnt_q == '0) ? bus.in_data : mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wl_d    = wl_q;
    par_d   = par_q;
    err_d   = err_q;
    pop     = 1'b0;
    flush   = 1'b0;
    avail   = cnt_q + CW'(push);
    if (push) acc_d = acc_q + 11'd1;

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FILL;
        flush   = 1'b1;
        acc_d   = '0;
        wl_d    = '0;
        err_d   = 1'b0;
      end
      // word 0 is popped on the way into LOAD so it appears with cpu_rst=01
      S_FILL: if ((avail >= PRIME_N) || (acc_d == CODE_N)) begin
        state_d = S_LOAD;
        pop     = 1'b1;
      end
      S_LOAD: begin
        if (wl_q == CODE_N) begin
          state_d = S_BOOT;
        end else if (avail == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          pop = 1'b1;
        end
      end
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      par_d = head;
      wl_d  = wl_q + 11'd1;
    end

    // halt overrides start and every transition; only the FIFO is touched
    if (halt) begin
      state_d = S_IDLE;
      flush   = 1'b1;
      pop     = 1'b0;
      acc_d   = acc_q;
      wl_d    = wl_q;
      par_d   = par_q;
      err_d   = err_q;
    end

    wr_d  = flush ? '0 : wr_q + AW'(push);
    rd_d  = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);

    cpu_rst_d = 2'b00;
    if (state_d == S_LOAD) cpu_rst_d = 2'b01;
    if ((state_d == S_BOOT) || (state_d == S_RUN)) cpu_rst_d = 2'b10;
    boot_d = (state_d == S_BOOT);
    run_d  = (state_d == S_RUN);
    busy_d = (state_d == S_FILL) || (state_d == S_LOAD) || (state_d == S_BOOT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      wl_q      <= '0;
      par_q     <= 16'h8000;
      err_q     <= 1'b0;
      cpu_rst_q <= 2'b00;
      boot_q    <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wl_q      <= wl_d;
      par_q     <= par_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
      boot_q    <= boot_d;
      run_q     <= run_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.par       = par_q;
  assign bus.boot_done = boot_q;
  assign running       = run_q;
  assign busy          = busy_q;
  assign err_underrun  = err_q;
  assign words_loaded  = wl_q;
endmodule

// File: tb/tb_cpu_boot_seq.sv
// Bench for cpu_boot_seq: queue-based cycle model for an 8-word image, plus a
// directed short-image instance with CODE_WORDS < PRIME.
module tb_cpu_boot_seq;
  localparam int A_CW = 8, A_DEPTH = 4, A_PRIME = 4;
  localparam int P_IDLE = 0, P_FILL = 1, P_LOAD = 2, P_BOOT = 3, P_RUN = 4;

  logic clk, rst_n;
  logic start_a, halt_a, running_a, busy_a, err_a;
  logic start_s, halt_s, running_s, busy_s, err_s;
  logic [10:0] wl_a, wl_s;
  int n_cmp, n_err;

  cpu_boot_seq_if ba ();
  cpu_boot_seq_if bs ();

  cpu_boot_seq #(.CODE_WORDS(A_CW), .FIFO_DEPTH(A_DEPTH), .PRIME(A_PRIME)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .halt(halt_a), .bus(ba),
    .running(running_a), .busy(busy_a), .err_underrun(err_a), .words_loaded(wl_a));

  cpu_boot_seq #(.CODE_WORDS(3), .FIFO_DEPTH(16), .PRIME(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .halt(halt_s), .bus(bs),
    .running(running_s), .busy(busy_s), .err_underrun(err_s), .words_loaded(wl_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: spec phases over a word queue
  int          m_ph, m_acc, m_wl;
  logic [15:0] m_q[$];
  logic [15:0] m_par;
  logic        m_err;

  function automatic logic m_rdy();
    return ((m_ph == P_FILL) || (m_ph == P_LOAD)) && (m_q.size() < A_DEPTH) && (m_acc < A_CW);
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE; m_q.delete(); m_acc = 0; m_wl = 0; m_par = 16'h8000; m_err = 1'b0;
  endtask

  task automatic m_step(input logic s, input logic h, input logic v, input logic [15:0] d);
    logic push;
    push = v && m_rdy();
    if (h) begin
      m_ph = P_IDLE;
      m_q.delete();
      return;
    end
    if (push) begin m_q.push_back(d); m_acc++; end
    case (m_ph)
      P_IDLE: if (s) begin
        m_ph = P_FILL; m_q.delete(); m_acc = 0; m_wl = 0; m_err = 1'b0;
      end
      P_FILL: if ((m_q.size() >= A_PRIME) || (m_acc == A_CW)) begin
        m_par = m_q.pop_front(); m_wl++; m_ph = P_LOAD;
      end
      P_LOAD: begin
        if (m_wl == A_CW) m_ph = P_BOOT;
        else if (m_q.size() == 0) begin m_err = 1'b1; m_ph = P_IDLE; end
        else begin m_par = m_q.pop_front(); m_wl++; end
      end
      P_BOOT: m_ph = P_RUN;
      default: ;
    endcase
  endtask

  logic [15:0] load_q[$];
  int          nboot;
  logic        last_acc;

  // one clock on dut_a: drive, check at negedge, advance model
  task automatic cyc(input logic s, input logic h, input logic v, input logic [15:0] d);
    logic [1:0] ecr;
    start_a = s; halt_a = h; ba.in_valid = v; ba.in_data = d;
    @(negedge clk);
    ecr = (m_ph == P_LOAD) ? 2'b01 : ((m_ph == P_BOOT) || (m_ph == P_RUN)) ? 2'b10 : 2'b00;
    chk("in_ready", ba.in_ready, m_rdy());
    chk("cpu_rst", ba.cpu_rst, ecr);
    chk("par", ba.par, m_par);
    chk("boot_done", ba.boot_done, m_ph == P_BOOT);
    chk("running", running_a, m_ph == P_RUN);
    chk("busy", busy_a, (m_ph == P_FILL) || (m_ph == P_LOAD) || (m_ph == P_BOOT));
    chk("err_underrun", err_a, m_err);
    chk("words_loaded", wl_a, m_wl);
    if (ba.cpu_rst == 2'b01) load_q.push_back(ba.par);
    if (ba.boot_done) nboot++;
    last_acc = v && ba.in_ready;
    m_step(s, h, v, d);
    @(posedge clk); #1;
  endtask

  initial begin
    int idx, c, first_load, nload, acc;
    logic [15:0] sq[$];
    n_cmp = 0; n_err = 0; nboot = 0;
    rst_n = 1'b0; start_a = 0; halt_a = 0; start_s = 0; halt_s = 0;
    ba.in_valid = 0; ba.in_data = '0; bs.in_valid = 0; bs.in_data = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_par", ba.par, 16'h8000);
    chk("rst_cpu_rst", ba.cpu_rst, 2'b00);
    chk("rst_busy", busy_a, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // nominal load, host streams with no gaps
    cyc(1, 0, 0, 16'h0);
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, idx < 8, 16'h1000 + 16'(idx));
      if (last_acc) idx++;
    end
    chk("nom_nload", load_q.size(), 8);
    for (int i = 0; i < 8 && i < load_q.size(); i++) chk("nom_word", load_q[i], 16'h1000 + 16'(i));
    chk("nom_nboot", nboot, 1);
    chk("nom_wl", wl_a, 11'd8);
    chk("nom_running", running_a, 1'b1);

    // halt in RUN, start while running ignored first
    cyc(1, 0, 1, 16'h5555);
    cyc(0, 1, 0, 16'h0);
    cyc(0, 0, 0, 16'h0);
    chk("halt_run_cpu_rst", ba.cpu_rst, 2'b00);

    // underrun: 4 words then a 10-cycle pause
    cyc(1, 0, 0, 16'h0);
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, idx < 4, 16'h2000 + 16'(idx));
      if (last_acc) idx++;
    end
    chk("ur_err", err_a, 1'b1);
    chk("ur_cpu_rst", ba.cpu_rst, 2'b00);
    chk("ur_wl", wl_a, 11'd4);
    cyc(1, 0, 0, 16'h0);
    cyc(0, 1, 0, 16'h0);
    chk("ur_cleared", err_a, 1'b0);

    // halt + start together from FILL, then halt mid-LOAD
    cyc(1, 0, 0, 16'h0);
    cyc(1, 1, 1, 16'h3000);
    cyc(0, 0, 0, 16'h0);
    chk("hs_busy", busy_a, 1'b0);
    cyc(1, 0, 0, 16'h0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 16'h3100 + 16'(i));
    chk("hl_in_load", ba.cpu_rst, 2'b01);
    cyc(0, 1, 1, 16'h3200);
    cyc(0, 0, 0, 16'h0);
    chk("hl_cpu_rst", ba.cpu_rst, 2'b00);

    // randomized traffic with occasional start/halt
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(15) == 0, $urandom_range(80) == 0, $urandom_range(3) != 0, 16'($urandom));

    // asynchronous reset pulse inside LOAD
    cyc(0, 1, 0, 16'h0);
    cyc(1, 0, 0, 16'h0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 16'h4000 + 16'(i));
    chk("ar_in_load", ba.cpu_rst, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cpu_rst", ba.cpu_rst, 2'b00);
    chk("ar_par", ba.par, 16'h8000);
    chk("ar_boot_done", ba.boot_done, 1'b0);
    chk("ar_running", running_a, 1'b0);
    chk("ar_busy", busy_a, 1'b0);
    chk("ar_err", err_a, 1'b0);
    chk("ar_wl", wl_a, 11'd0);
    chk("ar_in_ready", ba.in_ready, 1'b0);
    #1 rst_n = 1'b1;
    m_reset();
    ba.in_valid = 0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 16'h0);

    // short image on the CODE_WORDS=3 instance
    start_s = 1; bs.in_valid = 1; bs.in_data = 16'h6000;
    @(posedge clk); #1;
    start_s = 0;
    acc = 0; first_load = -1; nload = 0; c = 0;
    for (int k = 1; k <= 12; k++) begin
      bs.in_data = 16'h6000 + 16'(acc);
      @(negedge clk);
      if (bs.cpu_rst == 2'b01) begin
        if (first_load < 0) first_load = k;
        nload++;
        sq.push_back(bs.par);
      end
      if (bs.boot_done) c++;
      if (bs.in_ready) acc++;
      @(posedge clk); #1;
    end
    bs.in_valid = 0;
    chk("short_accepts", acc, 3);
    chk("short_first_load", first_load, 4);
    chk("short_nload", nload, 3);
    chk("short_nboot", c, 1);
    for (int i = 0; i < 3 && i < sq.size(); i++) chk("short_word", sq[i], 16'h6000 + 16'(i));
    chk("short_running", running_s, 1'b1);
    chk("short_wl", wl_s, 11'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
